pt_fetcher: RTL and testbench

PT_FETCHER -- requirements
Module: pt_fetcher

---
 rtl/pt_fetcher.sv | 110 +++++++++++
 tb/tb_pt_fetcher.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pt_fetcher.sv
// Pixel read-modify-write fetcher: merges an 18-bit pixel into its half of a 36-bit memory word.
// Optional write coalescing of the partner pixel while the write waits: define PTF_COALESCE_EN.
module pt_fetcher #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int MEM_BITS     = 36,
  parameter int PIX_BITS     = 18,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pt_flag,
  input  logic [WIDTH_BITS-1:0]  pt_x,
  input  logic [HEIGHT_BITS-1:0] pt_y,
  input  logic [PIX_BITS-1:0]    pt_pixel,
  output logic                   done_pt,
  output logic                   ptf_flag,
  output logic                   ptf_wr,
  output logic [WIDTH_BITS-1:0]  ptf_x,
  output logic [HEIGHT_BITS-1:0] ptf_y,
  output logic [MEM_BITS-1:0]    ptf_pixel_write,
  input  logic                   done_ptf,
  input  logic [MEM_BITS-1:0]    ptf_pixel_read,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  localparam int CNT_BITS = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t                 state, state_next;
  logic [WIDTH_BITS-1:0]  x_q;
  logic [HEIGHT_BITS-1:0] y_q;
  logic [PIX_BITS-1:0]    pix_q;
  logic [MEM_BITS-1:0]    word_q;
  logic [CNT_BITS-1:0]    cnt_q;
  logic                   accept, capture, coalesce, req;

  // Even x owns the upper half of the word, odd x the lower half.
  function automatic logic [MEM_BITS-1:0] merge(input logic [MEM_BITS-1:0] w,
                                                input logic odd,
                                                input logic [PIX_BITS-1:0] p);
    return odd ? {w[MEM_BITS-1:PIX_BITS], p} : {p, w[PIX_BITS-1:0]};
  endfunction

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    coalesce   = 1'b0;
    case (state)
      IDLE:    if (pt_flag) begin
                 accept     = 1'b1;
                 state_next = RD_REQ;
               end
      RD_REQ:  if (done_ptf) state_next = RD_WAIT;
      RD_WAIT: if (cnt_q == '0) begin
                 capture    = 1'b1;
                 state_next = WR_REQ;
               end
      WR_REQ: begin
        if (done_ptf) state_next = IDLE;
`ifdef PTF_COALESCE_EN
        else if (pt_flag && pt_y == y_q && pt_x[WIDTH_BITS-1:1] == x_q[WIDTH_BITS-1:1])
          coalesce = 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are gated by reset so nothing leaks during the reset cycle itself.
  always_comb begin
    req             = !reset && (state == RD_REQ || state == WR_REQ);
    done_pt         = !reset && (accept || coalesce);
    busy            = !reset && (state != IDLE);
    ptf_flag        = req;
    ptf_wr          = req && (state == WR_REQ);
    ptf_x           = req ? x_q : '0;
    ptf_y           = req ? y_q : '0;
    ptf_pixel_write = (req && state == WR_REQ) ? word_q : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      pix_q  <= '0;
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        x_q   <= pt_x;
        y_q   <= pt_y;
        pix_q <= pt_pixel;
      end
      if (state == RD_REQ && done_ptf)
        cnt_q <= CNT_BITS'(READ_LATENCY - 1);
      else if (state == RD_WAIT && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
      if (capture)
        word_q <= merge(ptf_pixel_read, x_q[0], pix_q);
      else if (coalesce)
        word_q <= merge(word_q, pt_x[0], pt_pixel);
    end
  end

endmodule

// File: tb/tb_pt_fetcher.sv
// Directed self-checking bench for pt_fetcher with a hand-driven arbiter (READ_LATENCY = 2).
module tb_pt_fetcher;

  localparam int WB = 10;
  localparam int HB = 9;
  localparam int MB = 36;
  localparam int PB = 18;

  logic          clock = 1'b0;
  logic          reset;
  logic          pt_flag;
  logic [WB-1:0] pt_x;
  logic [HB-1:0] pt_y;
  logic [PB-1:0] pt_pixel;
  logic          done_pt;
  logic          ptf_flag;
  logic          ptf_wr;
  logic [WB-1:0] ptf_x;
  logic [HB-1:0] ptf_y;
  logic [MB-1:0] ptf_pixel_write;
  logic          done_ptf;
  logic [MB-1:0] ptf_pixel_read;
  logic          busy;

  pt_fetcher #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .MEM_BITS(MB), .PIX_BITS(PB), .READ_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .pt_flag(pt_flag), .pt_x(pt_x), .pt_y(pt_y),
    .pt_pixel(pt_pixel), .done_pt(done_pt), .ptf_flag(ptf_flag), .ptf_wr(ptf_wr),
    .ptf_x(ptf_x), .ptf_y(ptf_y), .ptf_pixel_write(ptf_pixel_write),
    .done_ptf(done_ptf), .ptf_pixel_read(ptf_pixel_read), .busy(busy)
  );

  always #5 clock = ~clock;

  localparam logic [MB-1:0] RD   = 36'h111122222;
  localparam logic [MB-1:0] JUNK = 36'hFFFFFFFFF;
  localparam logic [PB-1:0] RD_HI = 18'h04444;  // RD[35:18]
  localparam logic [PB-1:0] RD_LO = 18'h22222;  // RD[17:0]

  int passed = 0;
  int total  = 0;
  int wr_count = 0;
  int dpt_count = 0;
  logic [WB+HB+MB-1:0] wq[$];

  always @(posedge clock) begin
    if (done_pt) dpt_count++;
    if (ptf_flag && ptf_wr && done_ptf) begin
      wr_count++;
      wq.push_back({ptf_x, ptf_y, ptf_pixel_write});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full RMW with immediate acceptance; read data valid only in the grant+2 cycle.
  task automatic rmw(input string tag, input logic [WB-1:0] x, input logic [HB-1:0] y,
                     input logic [PB-1:0] pix, input int rstall, input int wstall,
                     input logic [MB-1:0] exp_word);
    int w0, d0;
    w0 = wr_count;
    d0 = dpt_count;
    pt_flag = 1'b1; pt_x = x; pt_y = y; pt_pixel = pix;
    #1;
    check({tag, ".accept"}, 64'(done_pt), 64'd1);
    tick();
    pt_flag = 1'b0;
    for (int i = 0; i < rstall; i++) begin
      done_ptf = 1'b0;
      #1;
      check({tag, ".rd_hold"}, {ptf_flag, ptf_wr, ptf_x, ptf_y}, {1'b1, 1'b0, x, y});
      tick();
    end
    done_ptf = 1'b1;
    #1;
    check({tag, ".rd_req"}, {ptf_flag, ptf_wr, ptf_x, ptf_y}, {1'b1, 1'b0, x, y});
    tick();
    done_ptf = 1'b0;
    ptf_pixel_read = JUNK;
    check({tag, ".rd_wait"}, {busy, ptf_flag}, {1'b1, 1'b0});
    tick();
    ptf_pixel_read = RD;
    tick();
    ptf_pixel_read = JUNK;
    for (int i = 0; i < wstall; i++) begin
      #1;
      check({tag, ".wr_hold"}, {ptf_flag, ptf_wr, ptf_x, ptf_y, ptf_pixel_write},
            {1'b1, 1'b1, x, y, exp_word});
      tick();
    end
    done_ptf = 1'b1;
    #1;
    check({tag, ".wr_req"}, {ptf_flag, ptf_wr, ptf_x, ptf_y, ptf_pixel_write},
          {1'b1, 1'b1, x, y, exp_word});
    tick();
    done_ptf = 1'b0;
    check({tag, ".idle"}, {busy, ptf_flag}, {1'b0, 1'b0});
    check({tag, ".writes"}, 64'(wr_count - w0), 64'd1);
    check({tag, ".pulses"}, 64'(dpt_count - d0), 64'd1);
  endtask

  initial begin
    int w0, d0, idx, cyc;
    logic acc;
    logic [PB-1:0] pa, pb;
    logic [WB-1:0] sx[3];
    logic [HB-1:0] sy[3];
    logic [PB-1:0] sp[3];
    logic [MB-1:0] sw[3];

    reset = 1'b1; pt_flag = 1'b1; pt_x = 10'd1; pt_y = 9'd1; pt_pixel = 18'h1;
    done_ptf = 1'b0; ptf_pixel_read = JUNK;
    tick(); tick();
    check("reset.outputs", {done_pt, busy, ptf_flag, ptf_wr, ptf_x, ptf_y, ptf_pixel_write}, '0);
    pt_flag = 1'b0;
    reset = 1'b0;
    tick();
    check("reset.idle", {done_pt, busy, ptf_flag}, '0);

    // odd x replaces lower half, even x upper half
    rmw("single_odd", 10'd5, 9'd3, 18'h2ABCD, 0, 0, {RD_HI, 18'h2ABCD});
    rmw("single_even", 10'd4, 9'd3, 18'h2ABCD, 0, 0, {18'h2ABCD, RD_LO});
    rmw("stalls", 10'd1023, 9'd511, 18'h3FFFF, 7, 4, {RD_HI, 18'h3FFFF});

    // reset in RD_WAIT, late read return must be ignored
    w0 = wr_count;
    pt_flag = 1'b1; pt_x = 10'd20; pt_y = 9'd5; pt_pixel = 18'h12345;
    tick();
    pt_flag = 1'b0;
    done_ptf = 1'b1;
    tick();
    done_ptf = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid.outputs", {busy, ptf_flag}, {1'b0, 1'b0});
    tick();
    reset = 1'b0;
    ptf_pixel_read = RD;
    done_ptf = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("rst_mid.quiet", {busy, ptf_flag, ptf_pixel_write}, '0);
    check("rst_mid.no_write", 64'(wr_count - w0), 64'd0);
    done_ptf = 1'b0;
    ptf_pixel_read = JUNK;

    // pair (6,2)=A then (7,2)=B presented during a stalled write
    pa = 18'h0AAAA; pb = 18'h1BBBB;
    w0 = wr_count; d0 = dpt_count;
    pt_flag = 1'b1; pt_x = 10'd6; pt_y = 9'd2; pt_pixel = pa;
    tick();
    pt_x = 10'd7; pt_pixel = pb;
    done_ptf = 1'b1;
    #1;
    check("pair.rd_req_no_accept", 64'(done_pt), 64'd0);
    tick();
    done_ptf = 1'b0;
    tick();
    ptf_pixel_read = RD;
    tick();
    ptf_pixel_read = JUNK;
`ifdef PTF_COALESCE_EN
    check("pair.coalesce_accept", 64'(done_pt), 64'd1);
    tick();
    pt_flag = 1'b0;
    check("pair.word", 64'(ptf_pixel_write), 64'({pa, pb}));
`else
    check("pair.stall_no_accept", 64'(done_pt), 64'd0);
    tick();
    check("pair.word", 64'(ptf_pixel_write), 64'({pa, RD_LO}));
`endif
    done_ptf = 1'b1;
    tick();
    done_ptf = 1'b0;
`ifdef PTF_COALESCE_EN
    check("pair.writes", 64'(wr_count - w0), 64'd1);
`else
    rmw("pair_b", 10'd7, 9'd2, pb, 0, 0, {RD_HI, pb});
    check("pair.writes", 64'(wr_count - w0), 64'd2);
`endif
    check("pair.pulses", 64'(dpt_count - d0), 64'd2);

    // pt_flag held with three pixels, arbiter grants immediately
    sx = '{10'd10, 10'd11, 10'd12};
    sy = '{9'd1, 9'd1, 9'd2};
    sp = '{18'h00AAA, 18'h15555, 18'h3F00F};
    sw = '{{18'h00AAA, RD_LO}, {RD_HI, 18'h15555}, {18'h3F00F, RD_LO}};
    w0 = wr_count; d0 = dpt_count;
    idx = 0; cyc = 0;
    ptf_pixel_read = RD;
    pt_flag = 1'b1;
    while (!(idx == 3 && !busy) && cyc < 80) begin
      if (idx < 3) begin
        pt_x = sx[idx]; pt_y = sy[idx]; pt_pixel = sp[idx];
      end else pt_flag = 1'b0;
      done_ptf = ptf_flag;
      #1;
      acc = done_pt;
      tick();
      if (acc) idx++;
      cyc++;
    end
    pt_flag = 1'b0;
    done_ptf = 1'b0;
    check("stream.timeout", 64'(cyc < 80), 64'd1);
    check("stream.pulses", 64'(dpt_count - d0), 64'd3);
    check("stream.writes", 64'(wr_count - w0), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (wq.size() > 0) check($sformatf("stream.write%0d", i), 64'(wq[wq.size() - 3 + i]),
                               64'({sx[i], sy[i], sw[i]}));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
